// File: rtl/memory_bank.sv
// memory_bank: byte-strobed register-array memory with a valid/ready request
// port, one-cycle registered responses, address range checking and a
// self-timed bulk-clear sequencer that zeroes one word per cycle.
module memory_bank #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH/8-1:0] req_wstrb,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    output logic                    rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_error,
    input  logic                    clear_start,
    output logic                    busy
);

    localparam int NB = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [ADDR_WIDTH-1:0]   r_clr_idx;
    logic [ADDR_WIDTH-1:0]   w_clr_idx_nxt;
    logic                    w_clr_en;

    logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

    logic                    r_rsp_valid;
    logic [DATA_WIDTH-1:0]   r_rsp_rdata;
    logic                    r_rsp_error;

    logic                    w_accept;
    logic                    w_in_range;
    logic                    w_wr_en;
    logic [DATA_WIDTH-1:0]   w_rd_word;

    // clear_start wins over a same-cycle request, and nothing is accepted mid-clear
    assign req_ready  = reset_n && (r_state == ST_IDLE) && !clear_start;
    assign w_accept   = req_valid && req_ready;
    assign w_in_range = ({1'b0, req_addr} < DEPTH_EXT);
    assign w_wr_en    = w_accept && req_write && w_in_range;

    assign rsp_valid  = r_rsp_valid;
    assign rsp_rdata  = r_rsp_rdata;
    assign rsp_error  = r_rsp_error;
    assign busy       = (r_state == ST_CLEAR);

    // State register and clear-index counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_clr_idx <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_idx <= w_clr_idx_nxt;
        end
    end

    // Next-state logic: IDLE serves requests, CLEAR zeroes word clr_idx each cycle
    always_comb begin
        w_state_nxt   = r_state;
        w_clr_idx_nxt = r_clr_idx;
        w_clr_en      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (clear_start) begin
                    w_state_nxt   = ST_CLEAR;
                    w_clr_idx_nxt = '0;
                end else begin
                    w_state_nxt   = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                w_clr_en = 1'b1;
                if (r_clr_idx == LAST_IDX) begin
                    w_state_nxt   = ST_IDLE;
                    w_clr_idx_nxt = '0;
                end else begin
                    w_state_nxt   = ST_CLEAR;
                    w_clr_idx_nxt = r_clr_idx + ADDR_WIDTH'(1'b1);
                end
            end
            default: begin
                w_state_nxt   = ST_IDLE;
                w_clr_idx_nxt = '0;
            end
        endcase
    end

    // Read mux built as an AND-OR so out-of-range addresses never index the array
    always_comb begin
        w_rd_word = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_rd_word = w_rd_word
                      | ({DATA_WIDTH{req_addr == ADDR_WIDTH'(i)}} & r_mem[i]);
        end
    end

    // Storage: per-byte strobed writes in IDLE, whole-word zeroing during CLEAR
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                for (int b = 0; b < NB; b++) begin
                    if (w_clr_en && (r_clr_idx == ADDR_WIDTH'(i))) begin
                        r_mem[i][8*b +: 8] <= 8'h00;
                    end else if (w_wr_en && (req_addr == ADDR_WIDTH'(i)) && req_wstrb[b]) begin
                        r_mem[i][8*b +: 8] <= req_wdata[8*b +: 8];
                    end
                end
            end
        end
    end

    // Response registers: valid pulses for one cycle, data/error hold until the next response
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_error <= 1'b0;
        end else begin
            r_rsp_valid <= w_accept;
            if (w_accept) begin
                r_rsp_error <= !w_in_range;
                r_rsp_rdata <= (!req_write && w_in_range) ? w_rd_word : '0;
            end
        end
    end

endmodule

// File: doc/memory_bank.md
# memory_bank

Parametrised, byte-strobed register-array memory with a valid/ready request port, one-cycle registered responses, range checking and a self-timed bulk-clear sequencer. It generalises the single 32-bit memory word to DEPTH words of DATA_WIDTH bits. It is the data/scratch storage behind the CPU's load/store unit, and one instance serves one memory region.

## Interface
- DATA_WIDTH, default 32: word width in bits; must be a multiple of 8.
- DEPTH, default 16: number of words; need not be a power of two, minimum 2.
- ADDR_WIDTH, default $clog2(DEPTH): word-address width.
- clk  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted on a cycle where req_valid && req_ready.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  word address.
- req_wstrb  in  DATA_WIDTH/8  byte write enables; bit i covers bits [8i+7:8i].
- req_wdata  in  DATA_WIDTH  write data.
- rsp_valid  out  1  one-cycle pulse marking a response.
- rsp_rdata  out  DATA_WIDTH  read data.
- rsp_error  out  1  the accepted request addressed a word at or beyond DEPTH.
- clear_start  in  1  starts a bulk clear of every word.
- busy  out  1  a bulk clear is in progress.

## Operation
- Storage: DEPTH x DATA_WIDTH flops. All words are zero on reset.
- FSM states:
  - IDLE: the only state that accepts requests.
  - CLEAR: sweeps word index clr_idx from 0 to DEPTH-1, zeroing one word per cycle.
- IDLE -> CLEAR on clear_start and clr_idx <= 0. CLEAR -> IDLE on the edge that zeroes word DEPTH-1.
- clear_start is ignored while in CLEAR.
- req_ready = reset_n && state==IDLE && !clear_start. clear_start takes priority over a same-cycle request.
- Accepted write, in range: for each i with req_wstrb[i]=1, byte i of word[req_addr] <= req_wdata byte i. Other bytes are unchanged.
- Accepted write with wstrb=0 changes nothing but still produces a response.
- Accepted read, in range: the word value before the edge is captured into rsp_rdata.
- Accepted request with req_addr >= DEPTH:
  - no storage change;
  - rsp_error=1 and rsp_rdata=0.
- Write responses: rsp_rdata=0, rsp_error set per range rule.
- rsp_rdata and rsp_error hold their values until the next response. rsp_valid is a pulse.
- No response backpressure. The consumer must take rsp_* in the rsp_valid cycle.
- Single port: at most one access per cycle, so there are no read/write collisions.

## Timing
- Reset values while reset_n is low:
  - rsp_valid=0, rsp_rdata=0, rsp_error=0;
  - busy=0, req_ready=0;
  - state=IDLE, clr_idx=0, all words 0.
- Reset asserted mid-clear or mid-request aborts it. After release: IDLE, memory all zero, no pending response.
- Request acceptance is combinational on req_valid && req_ready. Accept at edge N gives rsp_valid high for the cycle after edge N, exactly one cycle.
- Back-to-back accepts every cycle give back-to-back rsp_valid with no bubbles, in order.
- Read of a word written on the immediately preceding accepted cycle returns the new data. Storage updates at the write's edge.
- Bulk clear:
  - clear_start sampled high in IDLE at edge N: busy=1 from after edge N.
  - Words 0..DEPTH-1 are zeroed at edges N+1..N+DEPTH.
  - busy=0 and req_ready may return to 1 after edge N+DEPTH.
  - A clear occupies DEPTH+1 cycles including the start cycle.
- A response pending from a request accepted in the same cycle as clear_start cannot exist, since req_ready=0 then. A response from the cycle before start is still delivered normally, during the first CLEAR cycle.

## Test plan
- Reset, then read every address 0..DEPTH-1 (defaults) -> each rsp_valid one cycle after accept, rsp_rdata=0, rsp_error=0.
- Write addr 3, wdata 0xAABBCCDD, wstrb 0xF. Then write addr 3, wdata 0x11223344, wstrb 0x5. Then read addr 3 back-to-back -> rsp_rdata=0xAA22CC44. Three consecutive rsp_valid pulses.
- DEPTH=12. Write addr 13, data 0xFFFFFFFF. Then read addr 13 -> both responses have rsp_error=1 and rsp_rdata=0. A read of addr 0..11 confirms no word changed.
- Fill words 0..15 with nonzero data, pulse clear_start with req_valid also high -> req_ready=0 that cycle, busy high for 16 cycles, req_ready=0 throughout. Afterwards all reads return 0.
- Assert reset_n low at clr_idx=7 during a clear -> busy=0 and req_ready=0 immediately. After release: idle, all words 0, rsp_valid stays 0 until a new request.
- Random mix of reads and writes with random strobes and addresses, including out-of-range ones, checked against a reference byte-array model -> every response matches in data, error and one-cycle latency.
